// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel used by the fetch stage.
// One request at a time: req/gnt accepts the address, rvalid returns the word.
interface pc_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time,
// and loads the IF/ID register with stall/flush handling.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | imem_req raised for pc; waiting for imem_gnt
// WAIT  | request accepted; waiting for imem_rvalid (kill=1 -> discard it)
// HOLD  | response captured in hold_pc/hold_instr while IF/ID is stalled
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     next_pc,
   input  logic            redirect,
   input  logic            stall,
   output logic [31:0]     pc_plus4,
   pc_fetch_unit_if.master imem,
   output logic            ifid_valid,
   output logic [31:0]     ifid_pc,
   output logic [31:0]     ifid_instr
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        kill;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;

   logic        deliver;
   logic [31:0] deliver_pc;
   logic [31:0] deliver_instr;

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_addr = pc;
   assign imem.imem_req  = (state == ST_REQ) & ~redirect & rst_n;

   // Instruction available to IF/ID this cycle: a live response in WAIT, or the held buffer.
   always_comb begin
      deliver       = 1'b0;
      deliver_pc    = pc;
      deliver_instr = imem.imem_rdata;
      if (state == ST_WAIT && !kill && imem.imem_rvalid) begin
         deliver = 1'b1;
      end else if (state == ST_HOLD) begin
         deliver       = 1'b1;
         deliver_pc    = hold_pc;
         deliver_instr = hold_instr;
      end
   end

   // Fetch sequencing; pc only moves on a delivery into IF/ID or on redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         hold_pc    <= 32'h0;
         hold_instr <= 32'h0;
      end else begin
         case (state)
            ST_REQ: begin
               if (redirect) begin
                  pc <= next_pc;
               end else if (imem.imem_gnt) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (kill) begin
                  // The outstanding response belongs to a squashed path.
                  if (redirect) begin
                     pc <= next_pc;
                  end
                  if (imem.imem_rvalid) begin
                     kill  <= 1'b0;
                     state <= ST_REQ;
                  end
               end else if (redirect) begin
                  pc <= next_pc;
                  if (imem.imem_rvalid) begin
                     state <= ST_REQ;
                  end else begin
                     kill <= 1'b1;
                  end
               end else if (imem.imem_rvalid) begin
                  if (stall) begin
                     hold_pc    <= pc;
                     hold_instr <= imem.imem_rdata;
                     state      <= ST_HOLD;
                  end else begin
                     pc    <= next_pc;
                     state <= ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               // A redirect simply abandons the buffer; its contents are never read again.
               if (redirect) begin
                  pc    <= next_pc;
                  state <= ST_REQ;
               end else if (!stall) begin
                  pc    <= next_pc;
                  state <= ST_REQ;
               end
            end
            default: begin
               state <= ST_REQ;
            end
         endcase
      end
   end

   // IF/ID register: flush beats stall, otherwise load or insert a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_valid <= 1'b0;
         ifid_pc    <= 32'h0;
         ifid_instr <= 32'h0;
      end else if (redirect) begin
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_valid <= deliver;
         if (deliver) begin
            ifid_pc    <= deliver_pc;
            ifid_instr <= deliver_instr;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Two instances share all stimulus:
// dut0 with RESET_PC = 0 and dut1 with RESET_PC = 32'hFFFFFFFC (wrap checks).
// A small memory responder answers dut0's grants after 1 + resp_delay cycles.
module tb_pc_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic        stall;
   logic [31:0] target;
   logic        gnt_en;
   logic [1:0]  resp_delay;

   logic [31:0] next_pc0, next_pc1;
   logic [31:0] pc_plus4_0, pc_plus4_1;
   logic        ifid_valid0, ifid_valid1;
   logic [31:0] ifid_pc0, ifid_pc1;
   logic [31:0] ifid_instr0, ifid_instr1;

   int tests_run;
   int tests_failed;

   pc_fetch_unit_if imem0 ();
   pc_fetch_unit_if imem1 ();

   pc_fetch_unit #(.RESET_PC(32'h00000000)) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .next_pc    (next_pc0),
      .redirect   (redirect),
      .stall      (stall),
      .pc_plus4   (pc_plus4_0),
      .imem       (imem0),
      .ifid_valid (ifid_valid0),
      .ifid_pc    (ifid_pc0),
      .ifid_instr (ifid_instr0)
   );

   pc_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .next_pc    (next_pc1),
      .redirect   (redirect),
      .stall      (stall),
      .pc_plus4   (pc_plus4_1),
      .imem       (imem1),
      .ifid_valid (ifid_valid1),
      .ifid_pc    (ifid_pc1),
      .ifid_instr (ifid_instr1)
   );

   // PC-source mux in front of each fetch unit.
   assign next_pc0 = redirect ? target : pc_plus4_0;
   assign next_pc1 = redirect ? target : pc_plus4_1;

   // Memory responder: latches a granted request, answers with addr + 0x13.
   logic        mem_pend;
   logic [1:0]  mem_cnt;
   logic [31:0] mem_addr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_pend <= 1'b0;
         mem_cnt  <= 2'd0;
         mem_addr <= 32'h0;
      end else if (mem_pend) begin
         if (mem_cnt == 2'd0) mem_pend <= 1'b0;
         else                 mem_cnt  <= mem_cnt - 2'd1;
      end else if (imem0.imem_req && gnt_en) begin
         mem_pend <= 1'b1;
         mem_cnt  <= resp_delay;
         mem_addr <= imem0.imem_addr;
      end
   end

   assign imem0.imem_gnt    = gnt_en & imem0.imem_req;
   assign imem0.imem_rvalid = mem_pend && (mem_cnt == 2'd0);
   assign imem0.imem_rdata  = mem_addr + 32'h13;
   assign imem1.imem_gnt    = gnt_en & imem1.imem_req;
   assign imem1.imem_rvalid = imem0.imem_rvalid;
   assign imem1.imem_rdata  = imem0.imem_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      redirect = 1'b0;
      stall    = 1'b0;
      target   = 32'h0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; target = 32'h0;
      gnt_en = 1'b1; resp_delay = 2'd0;
      step();
      step();
      #1;
      tests_run++;
      if ({imem0.imem_req, imem1.imem_req, ifid_valid0} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: req0/req1/valid got %b want 000",
                  {imem0.imem_req, imem1.imem_req, ifid_valid0});
      end
      tests_run++;
      if ({ifid_pc0, ifid_instr0, imem0.imem_addr} !== 96'h0) begin
         tests_failed++;
         $display("FAIL reset_regs: ifid_pc %h ifid_instr %h addr %h want all 0",
                  ifid_pc0, ifid_instr0, imem0.imem_addr);
      end
      tests_run++;
      if (imem1.imem_addr !== 32'hFFFFFFFC || pc_plus4_1 !== 32'h0 || pc_plus4_0 !== 32'h4) begin
         tests_failed++;
         $display("FAIL reset_pc: addr1 %h plus4_1 %h plus4_0 %h want fffffffc 0 4",
                  imem1.imem_addr, pc_plus4_1, pc_plus4_0);
      end
      step();
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (imem0.imem_req !== 1'b1 || imem0.imem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL first_req: req %b addr %h want 1 0", imem0.imem_req, imem0.imem_addr);
      end
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (imem0.imem_req !== 1'b1 || imem0.imem_addr !== 32'(4 * k)) begin
            tests_failed++;
            $display("FAIL seq_req%0d: req %b addr %h want 1 %h",
                     k, imem0.imem_req, imem0.imem_addr, 32'(4 * k));
         end
         if (k > 0) begin
            tests_run++;
            if (ifid_valid0 !== 1'b1 || ifid_pc0 !== 32'(4 * (k - 1)) ||
                ifid_instr0 !== 32'(4 * (k - 1) + 32'h13)) begin
               tests_failed++;
               $display("FAIL seq_ifid%0d: valid %b pc %h instr %h want 1 %h %h",
                        k, ifid_valid0, ifid_pc0, ifid_instr0,
                        32'(4 * (k - 1)), 32'(4 * (k - 1) + 32'h13));
            end
         end
         step();
         #1;
         tests_run++;
         if ({imem0.imem_req, ifid_valid0} !== 2'b00) begin
            tests_failed++;
            $display("FAIL seq_wait%0d: req/valid %b want 00", k, {imem0.imem_req, ifid_valid0});
         end
         step();
         #1;
      end
      tests_run++;
      if (ifid_valid0 !== 1'b1 || ifid_pc0 !== 32'h8 || ifid_instr0 !== 32'h1B ||
          imem0.imem_addr !== 32'hC) begin
         tests_failed++;
         $display("FAIL seq_last: valid %b pc %h instr %h addr %h want 1 8 1b c",
                  ifid_valid0, ifid_pc0, ifid_instr0, imem0.imem_addr);
      end
   endtask

   task automatic test_stall();
      gnt_en = 1'b1; resp_delay = 2'd0;
      do_reset();
      step(); #1;
      step(); #1;
      step(); stall = 1'b1; #1;
      tests_run++;
      if (imem0.imem_req !== 1'b0 || imem0.imem_rvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_wait: req %b rvalid %b want 0 1", imem0.imem_req, imem0.imem_rvalid);
      end
      step(); #1;
      tests_run++;
      if (imem0.imem_req !== 1'b0 || ifid_pc0 !== 32'h0 || ifid_valid0 !== 1'b0 ||
          imem0.imem_addr !== 32'h4) begin
         tests_failed++;
         $display("FAIL stall_hold1: req %b ifid_pc %h valid %b addr %h want 0 0 0 4",
                  imem0.imem_req, ifid_pc0, ifid_valid0, imem0.imem_addr);
      end
      step(); #1;
      tests_run++;
      if (imem0.imem_req !== 1'b0 || ifid_pc0 !== 32'h0) begin
         tests_failed++;
         $display("FAIL stall_hold2: req %b ifid_pc %h want 0 0", imem0.imem_req, ifid_pc0);
      end
      step(); stall = 1'b0; #1;
      tests_run++;
      if (imem0.imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_release: req %b want 0", imem0.imem_req);
      end
      step(); #1;
      tests_run++;
      if (ifid_valid0 !== 1'b1 || ifid_pc0 !== 32'h4 || ifid_instr0 !== 32'h17 ||
          imem0.imem_req !== 1'b1 || imem0.imem_addr !== 32'h8) begin
         tests_failed++;
         $display("FAIL stall_after: valid %b pc %h instr %h req %b addr %h want 1 4 17 1 8",
                  ifid_valid0, ifid_pc0, ifid_instr0, imem0.imem_req, imem0.imem_addr);
      end
   endtask

   task automatic test_redirect();
      gnt_en = 1'b1; resp_delay = 2'd2;
      do_reset();
      step(); redirect = 1'b1; target = 32'h100; #1;
      tests_run++;
      if (imem0.imem_req !== 1'b0 || imem0.imem_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_wait: req %b rvalid %b want 0 0", imem0.imem_req, imem0.imem_rvalid);
      end
      step(); redirect = 1'b0; #1;
      tests_run++;
      if (imem0.imem_addr !== 32'h100 || imem0.imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_addr: addr %h req %b want 100 0", imem0.imem_addr, imem0.imem_req);
      end
      step(); resp_delay = 2'd0; #1;
      tests_run++;
      if (imem0.imem_rvalid !== 1'b1 || imem0.imem_req !== 1'b0 || ifid_valid0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_late: rvalid %b req %b valid %b want 1 0 0",
                  imem0.imem_rvalid, imem0.imem_req, ifid_valid0);
      end
      step(); #1;
      tests_run++;
      if (imem0.imem_req !== 1'b1 || imem0.imem_addr !== 32'h100 || ifid_valid0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_discard: req %b addr %h valid %b want 1 100 0",
                  imem0.imem_req, imem0.imem_addr, ifid_valid0);
      end
      step(); #1;
      step(); #1;
      tests_run++;
      if (ifid_valid0 !== 1'b1 || ifid_pc0 !== 32'h100 || ifid_instr0 !== 32'h113) begin
         tests_failed++;
         $display("FAIL redir_target: valid %b pc %h instr %h want 1 100 113",
                  ifid_valid0, ifid_pc0, ifid_instr0);
      end
   endtask

   task automatic test_redirect_stall();
      gnt_en = 1'b1; resp_delay = 2'd0;
      do_reset();
      step(); #1;
      step(); redirect = 1'b1; stall = 1'b1; target = 32'h40; #1;
      tests_run++;
      if (ifid_valid0 !== 1'b1 || imem0.imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_pre: valid %b req %b want 1 0", ifid_valid0, imem0.imem_req);
      end
      step(); redirect = 1'b0; stall = 1'b0; #1;
      tests_run++;
      if (ifid_valid0 !== 1'b0 || ifid_pc0 !== 32'h0 || imem0.imem_addr !== 32'h40 ||
          imem0.imem_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_stall: valid %b pc %h addr %h req %b want 0 0 40 1",
                  ifid_valid0, ifid_pc0, imem0.imem_addr, imem0.imem_req);
      end
   endtask

   task automatic test_gnt_low();
      gnt_en = 1'b0; resp_delay = 2'd0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (imem0.imem_req !== 1'b1 || imem0.imem_addr !== 32'h0 || pc_plus4_0 !== 32'h4) begin
            tests_failed++;
            $display("FAIL gnt_low%0d: req %b addr %h plus4 %h want 1 0 4",
                     i, imem0.imem_req, imem0.imem_addr, pc_plus4_0);
         end
         step(); #1;
      end
      gnt_en = 1'b1;
      step(); #1;
      step(); #1;
      tests_run++;
      if (ifid_valid0 !== 1'b1 || ifid_pc0 !== 32'h0 || imem0.imem_addr !== 32'h4) begin
         tests_failed++;
         $display("FAIL gnt_resume: valid %b pc %h addr %h want 1 0 4",
                  ifid_valid0, ifid_pc0, imem0.imem_addr);
      end
   endtask

   task automatic test_reset_in_wait();
      gnt_en = 1'b1; resp_delay = 2'd0;
      do_reset();
      step(); #1;
      step(); stall = 1'b1; resp_delay = 2'd2; #1;
      step(); #1;
      tests_run++;
      if (ifid_valid0 !== 1'b1 || imem0.imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_pre: valid %b req %b want 1 0", ifid_valid0, imem0.imem_req);
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({ifid_valid0, imem0.imem_req, imem1.imem_req} !== 3'b000 || imem0.imem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_async: valid/req0/req1 %b addr %h want 000 0",
                  {ifid_valid0, imem0.imem_req, imem1.imem_req}, imem0.imem_addr);
      end
      stall = 1'b0; resp_delay = 2'd0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (imem0.imem_req !== 1'b1 || imem0.imem_addr !== 32'h0 ||
          imem1.imem_req !== 1'b1 || imem1.imem_addr !== 32'hFFFFFFFC) begin
         tests_failed++;
         $display("FAIL rst_restart: req0 %b addr0 %h req1 %b addr1 %h want 1 0 1 fffffffc",
                  imem0.imem_req, imem0.imem_addr, imem1.imem_req, imem1.imem_addr);
      end
      step(); #1;
      step(); #1;
      tests_run++;
      if (imem1.imem_req !== 1'b1 || imem1.imem_addr !== 32'h0 ||
          ifid_valid1 !== 1'b1 || ifid_pc1 !== 32'hFFFFFFFC || imem0.imem_addr !== 32'h4) begin
         tests_failed++;
         $display("FAIL wrap: req1 %b addr1 %h valid1 %b pc1 %h addr0 %h want 1 0 1 fffffffc 4",
                  imem1.imem_req, imem1.imem_addr, ifid_valid1, ifid_pc1, imem0.imem_addr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_gnt_low();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
